// File: rtl/hc595_frame_monitor_pkg.sv
// Shared 74HC595 attenuator link definitions: attenuator patterns, frame size and wire bit map.
package hc595_frame_monitor_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned ATT_W      = 6;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CNT_W      = 4;

    localparam logic [ATT_W-1:0] ATT_PAT_0 = 6'b000000;
    localparam logic [ATT_W-1:0] ATT_PAT_1 = 6'b000010;
    localparam logic [ATT_W-1:0] ATT_PAT_2 = 6'b000110;
    localparam logic [ATT_W-1:0] ATT_PAT_3 = 6'b001001;
    localparam logic [ATT_W-1:0] ATT_PAT_4 = 6'b001100;
    localparam logic [ATT_W-1:0] ATT_PAT_5 = 6'b110001;
    localparam logic [ATT_W-1:0] ATT_PAT_6 = 6'b011110;
    localparam logic [ATT_W-1:0] ATT_PAT_7 = 6'b101100;
    localparam logic [ATT_W-1:0] ATT_PAT_8 = 6'b111011;
    localparam logic [ATT_W-1:0] ATT_PAT_9 = 6'b111110;

    // Storage-register bit positions; wire order MSB first is {0, A4, A3, A5, A1, A0, A2, 0}
    localparam int unsigned POS_GUARD_HI = 7;
    localparam int unsigned POS_A4       = 6;
    localparam int unsigned POS_A3       = 5;
    localparam int unsigned POS_A5       = 4;
    localparam int unsigned POS_A1       = 3;
    localparam int unsigned POS_A0       = 2;
    localparam int unsigned POS_A2       = 1;
    localparam int unsigned POS_GUARD_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } mon_state_t;

    function automatic logic [ATT_W-1:0] frame_to_att(input logic [FRAME_BITS-1:0] f);
        frame_to_att = {f[POS_A5], f[POS_A4], f[POS_A3], f[POS_A2], f[POS_A1], f[POS_A0]};
    endfunction

endpackage

// File: rtl/hc595_att_decode.sv
// Maps a 6-bit attenuator pattern back to its index 0..9; hit_c is low for unknown patterns.
module hc595_att_decode
    import hc595_frame_monitor_pkg::*;
(
    input  logic [ATT_W-1:0] pat,
    output logic             hit_c,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        hit_c = 1'b1;
        idx_c = '0;
        case (pat)
            ATT_PAT_0: idx_c = 4'd0;
            ATT_PAT_1: idx_c = 4'd1;
            ATT_PAT_2: idx_c = 4'd2;
            ATT_PAT_3: idx_c = 4'd3;
            ATT_PAT_4: idx_c = 4'd4;
            ATT_PAT_5: idx_c = 4'd5;
            ATT_PAT_6: idx_c = 4'd6;
            ATT_PAT_7: idx_c = 4'd7;
            ATT_PAT_8: idx_c = 4'd8;
            ATT_PAT_9: idx_c = 4'd9;
            default:   hit_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/hc595_frame_monitor.sv
// Loopback checker for the 74HC595 attenuator link: rebuilds shift/storage registers
// from oversampled pins and decodes each latched frame to an attenuation index.
module hc595_frame_monitor
    import hc595_frame_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_SER,
    input  logic                  i_SRCLK,
    input  logic                  i_RCLK,
    input  logic                  i_SRCLR_n,
    output logic [FRAME_BITS-1:0] o_shift_q,
    output logic [FRAME_BITS-1:0] o_latch_q,
    output logic [IDX_W-1:0]      o_att_idx,
    output logic                  o_valid,
    output logic                  o_change,
    output logic                  o_err_len,
    output logic                  o_err_code
);

    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LAST  = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] ser_s, srclk_s, rclk_s, clr_s;
    logic                   srclk_d, rclk_d;
    logic                   sr_rise_c, rc_rise_c, clr_c;
    logic [FRAME_BITS-1:0]  shift_q, shift_nx_c, latch_q;
    logic [CNT_W-1:0]       cnt_q, cnt_nx_c;
    logic [TMO_W-1:0]       tmo_q;
    logic [IDX_W-1:0]       att_idx_q, dec_idx_c;
    logic                   dec_hit_c;
    mon_state_t             state_q;

    // Pin synchronizers plus one delayed copy of the last stage for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ser_s   <= '0;
            srclk_s <= '0;
            rclk_s  <= '0;
            clr_s   <= '1;
            srclk_d <= 1'b0;
            rclk_d  <= 1'b0;
        end else begin
            ser_s   <= {ser_s[SYNC_STAGES-2:0], i_SER};
            srclk_s <= {srclk_s[SYNC_STAGES-2:0], i_SRCLK};
            rclk_s  <= {rclk_s[SYNC_STAGES-2:0], i_RCLK};
            clr_s   <= {clr_s[SYNC_STAGES-2:0], i_SRCLR_n};
            srclk_d <= srclk_s[LAST];
            rclk_d  <= rclk_s[LAST];
        end
    end

    assign sr_rise_c = srclk_s[LAST] & ~srclk_d;
    assign rc_rise_c = rclk_s[LAST] & ~rclk_d;
    assign clr_c     = ~clr_s[LAST];

    // Shift register and bit count as the 595 would see them this cycle; clear beats shift
    always_comb begin
        shift_nx_c = shift_q;
        cnt_nx_c   = cnt_q;
        if (clr_c) begin
            shift_nx_c = '0;
            cnt_nx_c   = '0;
        end else if (sr_rise_c) begin
            shift_nx_c = {shift_q[FRAME_BITS-2:0], ser_s[LAST]};
            cnt_nx_c   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    hc595_att_decode u_decode (
        .pat   (frame_to_att(latch_q)),
        .hit_c (dec_hit_c),
        .idx_c (dec_idx_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            latch_q    <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            att_idx_q  <= '0;
            o_valid    <= 1'b0;
            o_change   <= 1'b0;
            o_err_len  <= 1'b0;
            o_err_code <= 1'b0;
        end else begin
            o_valid    <= 1'b0;
            o_change   <= 1'b0;
            o_err_len  <= 1'b0;
            o_err_code <= 1'b0;
            shift_q    <= shift_nx_c;
            cnt_q      <= cnt_nx_c;
            case (state_q)
                S_IDLE: begin
                    if (rc_rise_c) begin
                        latch_q <= shift_nx_c;
                        state_q <= S_CHECK;
                    end else if (sr_rise_c && !clr_c) begin
                        tmo_q   <= TMO_W'(TIMEOUT);
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (rc_rise_c) begin
                        latch_q <= shift_nx_c;
                        state_q <= S_CHECK;
                    end else if (clr_c) begin
                        state_q <= S_IDLE;
                    end else if (sr_rise_c) begin
                        tmo_q <= TMO_W'(TIMEOUT);
                    end else if (tmo_q == '0) begin
                        o_err_len <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - TMO_W'(1);
                    end
                end
                S_CHECK: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                    if (cnt_q != CNT_W'(FRAME_BITS)) begin
                        o_err_len <= 1'b1;
                    end else if (latch_q[POS_GUARD_HI] || latch_q[POS_GUARD_LO] || !dec_hit_c) begin
                        o_err_code <= 1'b1;
                    end else begin
                        att_idx_q <= dec_idx_c;
                        o_valid   <= 1'b1;
                        o_change  <= (dec_idx_c != att_idx_q);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_shift_q = shift_q;
    assign o_latch_q = latch_q;
    assign o_att_idx = att_idx_q;

endmodule
